pc_sequencer: RTL
=================

Name: pc_sequencer

Overview:
Fetch-stage controller that owns the fetch PC register (F_valP) and sequences each PC update. The sequential next address comes from next_pc (f_valP). The controller arbitrates it against execute-stage redirects, decode load-use stalls and writeback halt. It drives the instruction-memory request handshake and issues the flush bubbles into the D and E pipeline registers.

Parameters:
RESET_PC, 32'h0000_0000, F_valP value loaded on reset
REDIR_CNT_W, 16, width of the saturating redirect counter

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
f_valP  in  32  predicted next PC from next_pc
e_redirect  in  1  execute stage resolved taken branch or mispredict
e_target  in  32  redirect address, valid with e_redirect
d_stall  in  1  load-use stall request from decode
w_halt  in  1  halt instruction retired in writeback
imem_ready  in  1  instruction memory returns data this cycle
F_valP  out  32  current fetch PC, also imem address
imem_req  out  1  fetch request to instruction memory
f_valid  out  1  fetched instruction valid to decode this cycle
D_bubble  out  1  clear D pipeline register next edge
E_bubble  out  1  clear E pipeline register next edge
halted  out  1  sequencer in HALT
align_err  out  1  sticky misaligned redirect error
fetch_count  out  32  completed fetches, wraps
redir_count  out  REDIR_CNT_W  redirects taken, saturates at all-ones

Behaviour:
- Reset (async, rst_n=0): F_valP=RESET_PC, state=BOOT, all 1-bit outputs 0, both counters 0. Release is sampled at the next rising edge.
- States: BOOT, FETCH, WAIT, HALT.
- BOOT: imem_req=0 for 1 cycle, then go to FETCH.
- FETCH/WAIT: imem_req=1.
- Fetch completes on a cycle with imem_req && imem_ready.
  - On completion: f_valid=1 (combinational), fetch_count++.
  - If no other event, F_valP<=f_valP and state stays FETCH.
  - imem_req && !imem_ready: go to WAIT and hold F_valP. WAIT returns to FETCH on completion.
- Event priority, highest first, evaluated each cycle in FETCH/WAIT:
  1. w_halt
  2. misaligned redirect
  3. e_redirect
  4. d_stall
  5. completion
  6. hold
- w_halt: next state HALT. In HALT: imem_req=0, f_valid=0, F_valP frozen, halted=1. Only reset exits HALT. A redirect or stall in the same cycle as w_halt is ignored.
- e_redirect with e_target[1:0]!=0: align_err<=1 (sticky), then HALT. D_bubble=E_bubble=1 that cycle.
- e_redirect, aligned:
  - F_valP<=e_target; D_bubble=E_bubble=1 for exactly that cycle.
  - f_valid forced 0 even if imem_ready=1; fetch_count is not incremented.
  - redir_count++ unless saturated.
  - Next state FETCH. An outstanding WAIT is aborted; the memory must tolerate request abort.
- d_stall (no redirect): F_valP held, f_valid forced 0, E_bubble=1, D_bubble=0, fetch_count unchanged. Consecutive stall cycles each hold. The state stays as it was: FETCH stays FETCH, WAIT stays WAIT.
- d_stall with e_redirect in the same cycle: redirect wins and the stall is dropped.
- Redirect latency: e_target is on F_valP one cycle after e_redirect is sampled. It is fetched in that cycle if imem_ready=1.
- Outputs D_bubble, E_bubble and f_valid are combinational from state and inputs. F_valP, halted, align_err and the counters are registered.
- fetch_count wraps from 32'hFFFF_FFFF to 0.
- Reset asserted mid-WAIT or in HALT returns immediately to the reset values, with imem_req=0 asynchronously.

Test Plan:
- Reset, then imem_ready=1 and f_valP=F_valP+4 -> BOOT for 1 cycle, then F_valP sequence 0,4,8,12; f_valid=1 each FETCH cycle; fetch_count=3 after 3 fetches.
- At F_valP=4, e_redirect=1 with e_target=88 -> D_bubble=E_bubble=1 for 1 cycle, f_valid=0, next F_valP=88, redir_count=1, fetch_count unchanged that cycle.
- At F_valP=92, imem_ready=0 for 3 cycles, then 1 -> imem_req stays 1, F_valP stays 92 for 3 cycles, completes on 4th cycle, then F_valP=96.
- At F_valP=96, d_stall=1 for 2 cycles, then e_redirect=1 with e_target=200 and d_stall=1 -> F_valP=96 with E_bubble=1 for 2 cycles; redirect wins, F_valP=200, D_bubble=1.
- e_redirect=1 with e_target=102 -> align_err=1, halted=1, imem_req=0. Further redirects, e.g. to 300, are ignored. rst_n=0 clears everything back to F_valP=0.
- w_halt=1 and e_redirect=1 in the same cycle -> HALT, F_valP unchanged, redir_count unchanged. Force redir_count to 16'hFFFF, then redirect -> count stays 16'hFFFF.

Source files
------------

// File: rtl/pc_sequencer.sv
// Fetch-stage PC sequencer: owns F_valP, arbitrates halt/redirect/stall/completion,
// drives the imem request handshake and the D/E flush bubbles.
//
// state | meaning
// BOOT  | first cycle after reset, no request issued
// FETCH | request outstanding on F_valP, first cycle
// WAIT  | request outstanding on F_valP, memory not ready yet
// HALT  | frozen until reset
module pc_sequencer #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          REDIR_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [31:0]            f_valP,
  input  logic                   e_redirect,
  input  logic [31:0]            e_target,
  input  logic                   d_stall,
  input  logic                   w_halt,
  input  logic                   imem_ready,
  output logic [31:0]            F_valP,
  output logic                   imem_req,
  output logic                   f_valid,
  output logic                   D_bubble,
  output logic                   E_bubble,
  output logic                   halted,
  output logic                   align_err,
  output logic [31:0]            fetch_count,
  output logic [REDIR_CNT_W-1:0] redir_count
);

  localparam logic [1:0] S_BOOT  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_HALT  = 2'd3;

  logic [1:0]             r_state;
  logic [31:0]            r_pc;
  logic                   r_align_err;
  logic [31:0]            r_fetch_count;
  logic [REDIR_CNT_W-1:0] r_redir_count;

  logic [1:0]  w_next_state;
  logic [31:0] w_next_pc;
  logic        w_fetch_inc;
  logic        w_redir_inc;
  logic        w_set_aerr;
  logic        w_active;
  logic        w_misalign;

  assign w_active   = (r_state == S_FETCH) || (r_state == S_WAIT);
  assign w_misalign = e_redirect && (e_target[1:0] != 2'b00);

  always_comb begin
    w_next_state = r_state;
    w_next_pc    = r_pc;
    w_fetch_inc  = 1'b0;
    w_redir_inc  = 1'b0;
    w_set_aerr   = 1'b0;
    f_valid      = 1'b0;
    D_bubble     = 1'b0;
    E_bubble     = 1'b0;
    case (r_state)
      S_BOOT: w_next_state = S_FETCH;
      S_FETCH, S_WAIT: begin
        if (w_halt) begin
          w_next_state = S_HALT;
        end else if (w_misalign) begin
          w_set_aerr   = 1'b1;
          w_next_state = S_HALT;
          D_bubble     = 1'b1;
          E_bubble     = 1'b1;
        end else if (e_redirect) begin
          // A pending WAIT is simply abandoned; the new target is requested next cycle.
          w_next_pc    = e_target;
          w_redir_inc  = 1'b1;
          w_next_state = S_FETCH;
          D_bubble     = 1'b1;
          E_bubble     = 1'b1;
        end else if (d_stall) begin
          E_bubble = 1'b1;
        end else if (imem_ready) begin
          f_valid      = 1'b1;
          w_fetch_inc  = 1'b1;
          w_next_pc    = f_valP;
          w_next_state = S_FETCH;
        end else begin
          w_next_state = S_WAIT;
        end
      end
      default: w_next_state = S_HALT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_BOOT;
      r_pc          <= RESET_PC;
      r_align_err   <= 1'b0;
      r_fetch_count <= '0;
      r_redir_count <= '0;
    end else begin
      r_state <= w_next_state;
      r_pc    <= w_next_pc;
      if (w_set_aerr)
        r_align_err <= 1'b1;
      if (w_fetch_inc)
        r_fetch_count <= r_fetch_count + 32'd1;
      if (w_redir_inc && (r_redir_count != {REDIR_CNT_W{1'b1}}))
        r_redir_count <= r_redir_count + 1'b1;
    end
  end

  assign F_valP      = r_pc;
  assign imem_req    = w_active;
  assign halted      = (r_state == S_HALT);
  assign align_err   = r_align_err;
  assign fetch_count = r_fetch_count;
  assign redir_count = r_redir_count;

endmodule
